mont_result_unloader: RTL and testbench

Downstream stage of the 255-bit Montgomery multiplier over p = 2^255 − 19. Captures the multiplier's result on the rising edge of its `done`, performs the final conditional subtraction so the value is fully reduced into [0, p), and streams it out as eight 32-bit words, least-significant first, over a valid/ready handshake. It decouples the wide multiplier result bus from the 32-bit consumer (bus bridge / result FIFO).

---
 rtl/mont_result_unloader.sv | 163 ++++++++++++++++
 tb/tb_mont_result_unloader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mont_result_unloader.sv
// mont_result_unloader
// Captures the 255-bit Montgomery multiplier result on the rising edge of
// in_done and fully reduces it into [0, p), where p = 2^255 - P_C. The result
// is then streamed out as eight 32-bit words, least-significant word first,
// over a valid/ready handshake.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-low reset
//   in_data    multiplier result, valid while in_done is high
//   in_done    multiplier done flag; its 0->1 transition triggers a capture
//   out_word   current output word (registered)
//   out_valid  out_word is valid
//   out_last   high with word 7, the final word
//   out_ready  consumer accepts the word; transfer = out_valid & out_ready
//   busy       high while reducing or sending
//   err_drop   sticky; a capture edge arrived while busy and was dropped
module mont_result_unloader #(
  parameter int unsigned P_C = 19
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [254:0]   in_data,
  input  logic           in_done,
  output logic [31:0]    out_word,
  output logic           out_valid,
  output logic           out_last,
  input  logic           out_ready,
  output logic           busy,
  output logic           err_drop
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StReduce = 2'd1;
  localparam logic [1:0] StSend   = 2'd2;

  localparam logic [31:0] PcWord = P_C[31:0];

  logic [1:0]   state_q, state_d;
  logic         done_q;
  logic [255:0] v_q, v_d;
  logic [255:0] t_q, t_d;
  logic         carry_q, carry_d;
  logic [2:0]   idx_q, idx_d;
  logic [31:0]  out_word_q, out_word_d;
  logic         out_valid_q, out_valid_d;
  logic         out_last_q, out_last_d;
  logic         busy_q, busy_d;
  logic         err_drop_q, err_drop_d;

  logic         capture;
  logic         xfer;
  logic [7:0]   word_base;
  logic [7:0]   next_base;
  logic [31:0]  v_word;
  logic [31:0]  addend;
  logic [32:0]  sum;

  assign capture   = in_done & ~done_q;
  assign xfer      = out_valid_q & out_ready;
  assign word_base = {idx_q, 5'b0};
  assign next_base = {idx_d, 5'b0};
  assign v_word    = v_q[word_base +: 32];
  assign addend    = (idx_q == 3'd0) ? PcWord : 32'd0;
  // One 32-bit slice of v + P_C per REDUCE cycle, ripple carry kept in carry_q.
  assign sum       = {1'b0, v_word} + {1'b0, addend} + {32'd0, carry_q};

  always_comb begin
    state_d     = state_q;
    v_d         = v_q;
    t_d         = t_q;
    carry_d     = carry_q;
    idx_d       = idx_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    err_drop_d  = err_drop_q | (capture & (state_q != StIdle));

    unique case (state_q)
      StIdle: begin
        if (capture) begin
          v_d     = {1'b0, in_data};
          carry_d = 1'b0;
          idx_d   = 3'd0;
          state_d = StReduce;
        end
      end
      StReduce: begin
        t_d[word_base +: 32] = sum[31:0];
        carry_d              = sum[32];
        idx_d                = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          // t[255] set means v + P_C >= 2^255, i.e. v >= p; v - p is then t mod 2^255.
          if (t_d[255]) begin
            v_d = {1'b0, t_d[254:0]};
          end
          // Word 0 must be registered on this same edge so it is valid right after it.
          out_word_d  = t_d[255] ? t_d[31:0] : v_q[31:0];
          out_valid_d = 1'b1;
          out_last_d  = 1'b0;
          idx_d       = 3'd0;
          state_d     = StSend;
        end
      end
      StSend: begin
        if (xfer) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            out_word_d  = 32'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            state_d     = StIdle;
          end else begin
            out_word_d = v_q[next_base +: 32];
            out_last_d = (idx_d == 3'd7);
          end
        end
      end
      default: begin
        state_d     = StIdle;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      done_q      <= 1'b0;
      v_q         <= '0;
      t_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= 3'd0;
      out_word_q  <= 32'd0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      err_drop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_q      <= in_done;
      v_q         <= v_d;
      t_q         <= t_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign out_word  = out_word_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign err_drop  = err_drop_q;

endmodule

// File: tb/tb_mont_result_unloader.sv
// Scoreboard bench for mont_result_unloader: each accepted capture pushes the
// eight expected words of (in_data mod p) into a queue; a negedge monitor pops
// and compares on every transfer.
module tb_mont_result_unloader;

  localparam int unsigned PC = 19;
  localparam logic [255:0] PMOD = (256'd1 << 255) - 256'(PC);

  logic         clk;
  logic         rst;
  logic [254:0] in_data;
  logic         in_done;
  logic [31:0]  out_word;
  logic         out_valid;
  logic         out_last;
  logic         out_ready;
  logic         busy;
  logic         err_drop;

  mont_result_unloader #(.P_C(PC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_done   (in_done),
    .out_word  (out_word),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .busy      (busy),
    .err_drop  (err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          cyc = 0;
  int          cap_cyc = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pop = 0;
  int          rdy_mode = 0;
  int          rdy_cnt = 0;
  logic [32:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer model: 0 = always ready, 1 = random, 2 = one-in-three.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'($urandom_range(0, 1));
      default: begin
        out_ready = (rdy_cnt % 3 == 0);
        rdy_cnt++;
      end
    endcase
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference: plain modular reduction of the captured value.
  task automatic expect_stream(input logic [254:0] d);
    logic [255:0] x;
    x = {1'b0, d};
    if (x >= PMOD) x = x - PMOD;
    for (int k = 0; k < 8; k++) exp_q.push_back({(k == 7) ? 1'b1 : 1'b0, x[32*k +: 32]});
  endtask

  task automatic pulse(input logic [254:0] d, input int hold);
    @(posedge clk);
    #1;
    in_data = d;
    in_done = 1'b1;
    cap_cyc = cyc + 1;
    expect_stream(d);
    repeat (hold) @(posedge clk);
    #1;
    in_done = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("stream_drain", 64'(ok), 64'd1);
  endtask

  // Monitor
  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_word = 32'd0;
  logic        prev_last = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        check("first_word_latency", 64'(cyc - cap_cyc), 64'd8);
        check("busy_while_valid", 64'(busy), 64'd1);
      end
      if (prev_valid && !prev_ready) begin
        check("stall_hold", {30'd0, out_valid, out_last, out_word},
              {30'd0, 1'b1, prev_last, prev_word});
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {31'd0, out_last, out_word}, 64'h1_dead_beef_0);
        end else begin
          logic [32:0] e;
          e = exp_q.pop_front();
          check("word_last", {31'd0, out_last, out_word}, {31'd0, e});
          n_pop++;
        end
      end
      prev_valid = out_valid;
      prev_ready = out_ready;
      prev_word  = out_word;
      prev_last  = out_last;
    end
  end

  initial begin
    logic [254:0] d;
    logic [255:0] r;
    bit           ok;
    int           base;

    rst       = 1'b0;
    in_done   = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_word", 64'(out_word), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err_drop", 64'(err_drop), 64'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    // Small value and reduction boundaries
    rdy_mode = 0;
    pulse(255'h101, 1);
    wait_idle();
    pulse(PMOD[254:0], 1);
    wait_idle();
    d = '1;
    pulse(d, 1);
    wait_idle();
    d = PMOD[254:0] - 255'd1;
    pulse(d, 1);
    wait_idle();

    // Backpressure, result 5
    rdy_mode = 2;
    rdy_cnt  = 1;
    d = '1;
    d = d - 255'd13;
    pulse(d, 1);
    wait_idle();

    // Level in_done: exactly one stream, no drop
    rdy_mode = 0;
    pulse(255'h1234_5678_9abc, 40);
    wait_idle();
    repeat (5) @(negedge clk);
    check("level_no_drop", 64'(err_drop), 64'd0);

    // Dropped capture during SEND
    rdy_mode = 2;
    pulse(255'h5555_aaaa_0000_ffff, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_send", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    in_data = 255'habc;
    in_done = 1'b1;
    @(posedge clk);
    #1;
    in_done = 1'b0;
    @(negedge clk);
    check("drop_flag", 64'(err_drop), 64'd1);
    wait_idle();
    repeat (30) @(negedge clk);
    check("drop_sticky", 64'(err_drop), 64'd1);
    check("drop_no_stream", 64'(exp_q.size()), 64'd0);

    // Reset mid-SEND after word 3 transfers
    rdy_mode = 0;
    base = n_pop;
    pulse(255'hfeed_f00d_cafe_0123_4567_89ab_cdef, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_pop >= base + 4) begin
        ok = 1'b1;
        break;
      end
    end
    check("reach_word3", 64'(ok), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_word", 64'(out_word), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_last", 64'(out_last), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_err_drop", 64'(err_drop), 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #3;
    rst = 1'b1;
    pulse(255'h7, 1);
    wait_idle();

    // Randomized values, some near the modulus
    for (int n = 0; n < 20; n++) begin
      rdy_mode = int'($urandom_range(0, 1));
      for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
      case ($urandom_range(0, 2))
        0: d = r[254:0];
        1: d = PMOD[254:0] + 255'(r[3:0]) - 255'd8;
        default: begin
          d = '1;
          d = d - 255'(r[4:0]);
        end
      endcase
      pulse(d, 1 + int'($urandom_range(0, 3)));
      wait_idle();
    end
    check("final_no_drop", 64'(err_drop), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
